// File: rtl/joypad_pkg.sv
// rtl/joypad_pkg.sv - shared button indices and types for the NES joypad port
package joypad_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_X      = 8;
    localparam int BTN_Y      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    typedef logic [11:0] snes_btns_t;
    typedef logic [7:0]  nes_btns_t;

    // NES read order is A,B,Sel,Start,U,D,L,R; turbo fire is OR-ed onto A/B
    function automatic nes_btns_t to_nes(input snes_btns_t b, input logic auto_a, input logic auto_b);
        return {b[BTN_RIGHT:BTN_SELECT], b[BTN_B] | auto_b, b[BTN_A] | auto_a};
    endfunction

endpackage

// File: rtl/joypad_autofire.sv
// rtl/joypad_autofire.sv - one turbo-fire phase unit driven by a shared tick
module joypad_autofire (
    input  logic clk,
    input  logic resetn,
    input  logic tick,
    input  logic btn,
    output logic auto
);

    logic phase;

    // Phase rests at 1 while released so a fresh press fires on its first cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase <= 1'b1;
        end else if (!btn) begin
            phase <= 1'b1;
        end else if (tick) begin
            phase <= ~phase;
        end
    end

    assign auto = btn & phase;

endmodule

// File: rtl/nes_joypad_port.sv
// rtl/nes_joypad_port.sv - dual 4021-style serial joypad ports with swap, home combo and optional JOYPAD_AUTOFIRE_EN turbo
module nes_joypad_port
    import joypad_pkg::*;
#(
    parameter int FREQ        = 21_492_000,
    parameter int AUTOFIRE_HZ = 15,
    parameter int HOME_MS     = 1000
) (
    input  logic       clk,
    input  logic       resetn,
    input  snes_btns_t joy1,
    input  snes_btns_t joy2,
    input  logic       joy_swap,
    input  logic       joypad_strobe,
    input  logic [1:0] joypad_clock,
    output logic [1:0] joy_data,
    output logic       home
);

    localparam longint HOME_CYC_L = (longint'(HOME_MS) * longint'(FREQ)) / 64'd1000;
    localparam int     HOME_CYC   = int'(HOME_CYC_L);
    localparam int     HCW        = (HOME_CYC > 0) ? $clog2(HOME_CYC + 1) : 1;

    snes_btns_t          src_a;
    snes_btns_t          src_b;
    logic                a_turbo_a;
    logic                a_turbo_b;
    logic                b_turbo_a;
    logic                b_turbo_b;
    logic                unused_bits;
    logic [1:0][7:0]     sr;
    logic [1:0]          last_clk;
    nes_btns_t           load_a;
    nes_btns_t           load_b;
    logic [HCW-1:0]      home_cnt;
    logic                combo;

    // Physical-to-NES port routing, re-evaluated every cycle
    always_comb begin
        src_a = joy_swap ? joy2 : joy1;
        src_b = joy_swap ? joy1 : joy2;
    end

`ifdef JOYPAD_AUTOFIRE_EN
    localparam int DIV = FREQ / (2 * AUTOFIRE_HZ);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic          tick;

    assign tick = (div_cnt == DW'(DIV - 1));

    // Free-running divider shared by all four turbo units
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    joypad_autofire u_af_a_x (.clk(clk), .resetn(resetn), .tick(tick), .btn(src_a[BTN_X]), .auto(a_turbo_a));
    joypad_autofire u_af_a_y (.clk(clk), .resetn(resetn), .tick(tick), .btn(src_a[BTN_Y]), .auto(a_turbo_b));
    joypad_autofire u_af_b_x (.clk(clk), .resetn(resetn), .tick(tick), .btn(src_b[BTN_X]), .auto(b_turbo_a));
    joypad_autofire u_af_b_y (.clk(clk), .resetn(resetn), .tick(tick), .btn(src_b[BTN_Y]), .auto(b_turbo_b));

    assign unused_bits = ^{joy1[BTN_R:BTN_L], joy2[BTN_R:BTN_L]};
`else
    assign a_turbo_a   = 1'b0;
    assign a_turbo_b   = 1'b0;
    assign b_turbo_a   = 1'b0;
    assign b_turbo_b   = 1'b0;
    assign unused_bits = ^{joy1[BTN_R:BTN_X], joy2[BTN_R:BTN_X], 32'(AUTOFIRE_HZ)};
`endif

    assign load_a = to_nes(src_a, a_turbo_a, a_turbo_b);
    assign load_b = to_nes(src_b, b_turbo_a, b_turbo_b);

    // Parallel load while strobed (load beats a coincident edge), else shift in 1s on falling read clocks
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sr       <= '0;
            last_clk <= 2'b00;
        end else begin
            last_clk <= joypad_clock;
            if (joypad_strobe) begin
                sr[0] <= load_a;
                sr[1] <= load_b;
            end else begin
                for (int n = 0; n < 2; n++) begin
                    if (last_clk[n] && !joypad_clock[n]) begin
                        sr[n] <= {1'b1, sr[n][7:1]};
                    end
                end
            end
        end
    end

    assign joy_data = {sr[1][0], sr[0][0]};

    assign combo = joy1[BTN_SELECT] & joy1[BTN_DOWN];

    // Hold timer saturates at terminal so home fires once per continuous hold
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            home_cnt <= '0;
            home     <= 1'b0;
        end else if (!combo) begin
            home_cnt <= '0;
            home     <= 1'b0;
        end else if (home_cnt != HCW'(HOME_CYC)) begin
            home_cnt <= home_cnt + 1'b1;
            home     <= (home_cnt == HCW'(HOME_CYC - 1));
        end else begin
            home     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nes_joypad_port.sv
// tb/tb_nes_joypad_port.sv - directed self-checking bench for nes_joypad_port
module tb_nes_joypad_port;

`ifdef JOYPAD_AUTOFIRE_EN
    localparam bit AF_EN = 1'b1;
`else
    localparam bit AF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic [11:0] joy1;
    logic [11:0] joy2;
    logic        joy_swap;
    logic        joypad_strobe;
    logic [1:0]  joypad_clock;
    logic [1:0]  joy_data;
    logic        home;

    int n_vec = 0;
    int n_bad = 0;

    nes_joypad_port #(.FREQ(1000), .AUTOFIRE_HZ(50), .HOME_MS(10)) dut (
        .clk(clk), .resetn(resetn), .joy1(joy1), .joy2(joy2), .joy_swap(joy_swap),
        .joypad_strobe(joypad_strobe), .joypad_clock(joypad_clock),
        .joy_data(joy_data), .home(home)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_pulse();
        joypad_strobe = 1'b1;
        tick();
        joypad_strobe = 1'b0;
    endtask

    task automatic nes_clk(input int p);
        joypad_clock[p] = 1'b1;
        tick();
        joypad_clock[p] = 1'b0;
        tick();
    endtask

    logic [9:0] exp_reads;
    int         div_m;
    logic       ph_m;
    logic       exp_a;
    int         pulses;
    int         first_at;

    initial begin
        resetn = 1'b0; joy1 = '0; joy2 = '0; joy_swap = 1'b0;
        joypad_strobe = 1'b0; joypad_clock = 2'b00;
        tick(); tick();
        check("reset_data", 32'(joy_data), 32'h0);
        check("reset_home", 32'(home), 32'h0);
        resetn = 1'b1;
        tick();

        // basic read: A+Start, reads LSB first then 1s forever
        exp_reads = 10'b11_0000_1001;
        joy1 = 12'h009;
        strobe_pulse();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("basic_read%0d", i), 32'(joy_data[0]), 32'(exp_reads[i]));
            nes_clk(0);
        end

        // swap: NES port 1 sees joy2 (B only), port 2 sees joy1 (A only)
        joy1 = 12'h001; joy2 = 12'h002; joy_swap = 1'b1;
        strobe_pulse();
        check("swap_p1_a", 32'(joy_data[0]), 32'h0);
        check("swap_p2_a", 32'(joy_data[1]), 32'h1);
        nes_clk(0);
        check("swap_p1_b", 32'(joy_data[0]), 32'h1);
        nes_clk(1);
        check("swap_p2_b", 32'(joy_data[1]), 32'h0);
        joy_swap = 1'b0; joy2 = '0;

        // read clock falls while strobe is high: load wins, nothing shifts
        joy1 = 12'h001;
        joypad_strobe = 1'b1;
        tick();
        check("coll_load", 32'(joy_data[0]), 32'h1);
        joypad_clock[0] = 1'b1;
        tick();
        joypad_clock[0] = 1'b0;
        tick();
        check("coll_edge", 32'(joy_data[0]), 32'h1);
        joypad_strobe = 1'b0;
        tick();
        check("coll_after", 32'(joy_data[0]), 32'h1);
        nes_clk(0);
        check("coll_b", 32'(joy_data[0]), 32'h0);

        // turbo A from X with strobe held; divider restarts from reset
        resetn = 1'b0;
        tick();
        joy1 = 12'h100; joypad_strobe = 1'b1; resetn = 1'b1;
        div_m = 0; ph_m = 1'b1;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk);
            exp_a = AF_EN & ph_m;
            if (div_m == 9) begin
                ph_m  = ~ph_m;
                div_m = 0;
            end else begin
                div_m = div_m + 1;
            end
            #1;
            check($sformatf("turbo_c%0d", i), 32'(joy_data[0]), 32'(exp_a));
        end
        joy1 = 12'h000;
        tick();
        check("turbo_rel", 32'(joy_data[0]), 32'h0);
        tick();
        joy1 = 12'h100;
        tick();
        check("turbo_repress", 32'(joy_data[0]), 32'(AF_EN));
        joypad_strobe = 1'b0; joy1 = '0;
        tick();

        // home combo: one pulse after 10 held cycles, re-arms only after release
        joy1 = 12'h024;
        pulses = 0; first_at = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (home) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
        end
        check("home_pulses", 32'(pulses), 32'd1);
        check("home_cycle", 32'(first_at), 32'd10);
        joy1 = '0;
        tick(); tick();
        check("home_released", 32'(home), 32'h0);
        joy1 = 12'h024;
        pulses = 0; first_at = -1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (home) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
        end
        check("home_rearm_pulses", 32'(pulses), 32'd1);
        check("home_rearm_cycle", 32'(first_at), 32'd10);
        joy1 = '0;
        tick();

        // async reset in the middle of a read sequence
        joy1 = 12'h0FF;
        strobe_pulse();
        nes_clk(0); nes_clk(0); nes_clk(0);
        check("mid_before_rst", 32'(joy_data[0]), 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_async_rst", 32'(joy_data), 32'h0);
        tick();
        resetn = 1'b1;
        joy1 = 12'h005;
        strobe_pulse();
        check("reload_a", 32'(joy_data[0]), 32'h1);
        nes_clk(0);
        check("reload_b", 32'(joy_data[0]), 32'h0);
        nes_clk(0);
        check("reload_sel", 32'(joy_data[0]), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
